// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer: routes tagged beats into per-channel FIFOs.
// Optional strict A/B alternation checking is enabled by TDM_DEMUX_ALT_CHECK_EN.

module tdm_demux_2ch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Pointer and occupancy tracking; count spans 0..DEPTH so full/empty never alias
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; stale contents are harmless because count gates visibility
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL);
    assign empty = (count == '0);
endmodule

module tdm_demux_2ch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count,
    output logic             seq_err
);
    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;
    logic accept;

    // During reset the FIFOs are treated as empty, so in_ready reads 1
    assign in_ready = rst | (in_sel ? ~b_full : ~a_full);
    assign accept   = in_valid & ~rst & (in_sel ? ~b_full : ~a_full);
    assign push_a   = accept & ~in_sel;
    assign push_b   = accept & in_sel;

    assign a_valid  = ~rst & ~a_empty;
    assign b_valid  = ~rst & ~b_empty;
    assign pop_a    = a_valid & a_ready;
    assign pop_b    = b_valid & b_ready;

    tdm_demux_2ch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (in_data),
        .pop   (pop_a),
        .rdata (a_data),
        .full  (a_full),
        .empty (a_empty)
    );

    tdm_demux_2ch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (in_data),
        .pop   (pop_b),
        .rdata (b_data),
        .full  (b_full),
        .empty (b_empty)
    );

    // Delivered-beat counters, wrapping naturally at 256
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= 8'd0;
            b_count <= 8'd0;
        end else begin
            if (pop_a)
                a_count <= a_count + 8'd1;
            if (pop_b)
                b_count <= b_count + 8'd1;
        end
    end

`ifdef TDM_DEMUX_ALT_CHECK_EN
    logic exp_sel;
    logic err_q;

    // Tracker follows the accepted tag so one slip flags once, not forever after
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sel <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            exp_sel <= ~in_sel;
            if (in_sel != exp_sel)
                err_q <= 1'b1;
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif
endmodule
